dadda_mul8: RTL and testbench

- 8x8 unsigned integer multiplier built as a Dadda partial-product reduction tree, followed by a final carry-propagate adder and an output register.
- Used as a datapath arithmetic leaf. Produces the full 16-bit product one clock after the operands are sampled.
- No handshake. Throughput is one product per cycle.

---
 rtl/dadda_mul8_pkg.sv | 64 ++++++
 rtl/dadda_mul8_cells.sv | 22 ++
 rtl/dadda_mul8.sv | 165 ++++++++++++++++
 tb/tb_dadda_mul8.sv | 106 ++++++++++
 4 files changed

// File: rtl/dadda_mul8_pkg.sv
// Shared widths and the Dadda reduction schedule for the 8x8 multiplier.
// The schedule functions give the number of full/half adders per column for
// each stage, from which column heights and bit positions are derived.
package dadda_mul8_pkg;

    localparam int OPND_W = 8;
    localparam int PROD_W = 16;
    localparam int NCOLS  = 15;

    // Full adders placed in column c during stage s (heights 8->6->4->3->2).
    function automatic int fa_cnt(input int s, input int c);
        case (s)
            1:       return (c >= 7 && c <= 9) ? 1 : 0;
            2:       return (c == 5 || c == 11) ? 1 : ((c >= 6 && c <= 10) ? 2 : 0);
            3:       return (c >= 4 && c <= 12) ? 1 : 0;
            4:       return (c >= 3 && c <= 13) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    // Half adders placed in column c during stage s.
    function automatic int ha_cnt(input int s, input int c);
        case (s)
            1:       return (c >= 6 && c <= 8) ? 1 : 0;
            2:       return (c == 4 || c == 5) ? 1 : 0;
            3:       return (c == 3) ? 1 : 0;
            4:       return (c == 2) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    // Height of column c after stage s (stage 0 is the raw partial products).
    function automatic int hgt(input int s, input int c);
        int h;
        h = 0;
        if (c >= 0 && c < NCOLS) begin
            h = (c <= 7) ? c + 1 : 15 - c;
            for (int t = 1; t <= s; t++)
                h = h - 2 * fa_cnt(t, c) - ha_cnt(t, c) + fa_cnt(t, c - 1) + ha_cnt(t, c - 1);
        end
        return h;
    endfunction

    // Bits of column c that pass through stage s untouched.
    function automatic int pass_cnt(input int s, input int c);
        return hgt(s - 1, c) - 3 * fa_cnt(s, c) - 2 * ha_cnt(s, c);
    endfunction

    // Offset of column c inside the flat bit vector holding stage s.
    function automatic int off(input int s, input int c);
        int o;
        o = 0;
        for (int k = 0; k < c; k++)
            o = o + hgt(s, k);
        return o;
    endfunction

    // Flat index where carries arriving into column c of stage s begin.
    // Column layout: FA sums, HA sums, pass-through bits, incoming carries.
    function automatic int cin_idx(input int s, input int c);
        return off(s, c) + fa_cnt(s, c) + ha_cnt(s, c) + pass_cnt(s, c);
    endfunction

endpackage

// File: rtl/dadda_mul8_cells.sv
// Single-bit adder cells used by the reduction tree and the final adder.

module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b;
    assign cout = a & b;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/dadda_mul8.sv
// 8x8 unsigned Dadda multiplier: partial products, four 3:2/2:2 reduction
// stages, a ripple carry-propagate adder and a single output register.
// Each stage is a flat vector ordered column by column; the schedule in the
// package fixes where every sum, carry and pass-through bit lands.
module dadda_mul8
    import dadda_mul8_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [PROD_W-1:0] op
);

    logic [off(0, NCOLS)-1:0] w_s0;
    logic [off(1, NCOLS)-1:0] w_s1;
    logic [off(2, NCOLS)-1:0] w_s2;
    logic [off(3, NCOLS)-1:0] w_s3;
    logic [off(4, NCOLS)-1:0] w_s4;
    logic [PROD_W-1:0]        w_prod;
    logic [PROD_W-1:0]        r_op;

    // Partial products: bit a[j]&b[i] lands in column i+j, ordered by i.
    for (genvar i = 0; i < OPND_W; i++) begin : g_ppi
        for (genvar j = 0; j < OPND_W; j++) begin : g_ppj
            assign w_s0[off(0, i + j) + i - ((i + j > 7) ? i + j - 7 : 0)] = a[j] & b[i];
        end
    end

    // Stage 1: heights 8 -> 6.
    for (genvar c = 0; c < NCOLS; c++) begin : g_s1
        for (genvar i = 0; i < fa_cnt(1, c); i++) begin : g_fa
            full_adder u_fa (
                .a   (w_s0[off(0, c) + 3 * i]),
                .b   (w_s0[off(0, c) + 3 * i + 1]),
                .cin (w_s0[off(0, c) + 3 * i + 2]),
                .sum (w_s1[off(1, c) + i]),
                .cout(w_s1[cin_idx(1, c + 1) + i])
            );
        end
        for (genvar j = 0; j < ha_cnt(1, c); j++) begin : g_ha
            half_adder u_ha (
                .a   (w_s0[off(0, c) + 3 * fa_cnt(1, c) + 2 * j]),
                .b   (w_s0[off(0, c) + 3 * fa_cnt(1, c) + 2 * j + 1]),
                .sum (w_s1[off(1, c) + fa_cnt(1, c) + j]),
                .cout(w_s1[cin_idx(1, c + 1) + fa_cnt(1, c) + j])
            );
        end
        for (genvar p = 0; p < pass_cnt(1, c); p++) begin : g_pass
            assign w_s1[off(1, c) + fa_cnt(1, c) + ha_cnt(1, c) + p] =
                   w_s0[off(0, c) + 3 * fa_cnt(1, c) + 2 * ha_cnt(1, c) + p];
        end
    end

    // Stage 2: heights 6 -> 4.
    for (genvar c = 0; c < NCOLS; c++) begin : g_s2
        for (genvar i = 0; i < fa_cnt(2, c); i++) begin : g_fa
            full_adder u_fa (
                .a   (w_s1[off(1, c) + 3 * i]),
                .b   (w_s1[off(1, c) + 3 * i + 1]),
                .cin (w_s1[off(1, c) + 3 * i + 2]),
                .sum (w_s2[off(2, c) + i]),
                .cout(w_s2[cin_idx(2, c + 1) + i])
            );
        end
        for (genvar j = 0; j < ha_cnt(2, c); j++) begin : g_ha
            half_adder u_ha (
                .a   (w_s1[off(1, c) + 3 * fa_cnt(2, c) + 2 * j]),
                .b   (w_s1[off(1, c) + 3 * fa_cnt(2, c) + 2 * j + 1]),
                .sum (w_s2[off(2, c) + fa_cnt(2, c) + j]),
                .cout(w_s2[cin_idx(2, c + 1) + fa_cnt(2, c) + j])
            );
        end
        for (genvar p = 0; p < pass_cnt(2, c); p++) begin : g_pass
            assign w_s2[off(2, c) + fa_cnt(2, c) + ha_cnt(2, c) + p] =
                   w_s1[off(1, c) + 3 * fa_cnt(2, c) + 2 * ha_cnt(2, c) + p];
        end
    end

    // Stage 3: heights 4 -> 3.
    for (genvar c = 0; c < NCOLS; c++) begin : g_s3
        for (genvar i = 0; i < fa_cnt(3, c); i++) begin : g_fa
            full_adder u_fa (
                .a   (w_s2[off(2, c) + 3 * i]),
                .b   (w_s2[off(2, c) + 3 * i + 1]),
                .cin (w_s2[off(2, c) + 3 * i + 2]),
                .sum (w_s3[off(3, c) + i]),
                .cout(w_s3[cin_idx(3, c + 1) + i])
            );
        end
        for (genvar j = 0; j < ha_cnt(3, c); j++) begin : g_ha
            half_adder u_ha (
                .a   (w_s2[off(2, c) + 3 * fa_cnt(3, c) + 2 * j]),
                .b   (w_s2[off(2, c) + 3 * fa_cnt(3, c) + 2 * j + 1]),
                .sum (w_s3[off(3, c) + fa_cnt(3, c) + j]),
                .cout(w_s3[cin_idx(3, c + 1) + fa_cnt(3, c) + j])
            );
        end
        for (genvar p = 0; p < pass_cnt(3, c); p++) begin : g_pass
            assign w_s3[off(3, c) + fa_cnt(3, c) + ha_cnt(3, c) + p] =
                   w_s2[off(2, c) + 3 * fa_cnt(3, c) + 2 * ha_cnt(3, c) + p];
        end
    end

    // Stage 4: heights 3 -> 2.
    for (genvar c = 0; c < NCOLS; c++) begin : g_s4
        for (genvar i = 0; i < fa_cnt(4, c); i++) begin : g_fa
            full_adder u_fa (
                .a   (w_s3[off(3, c) + 3 * i]),
                .b   (w_s3[off(3, c) + 3 * i + 1]),
                .cin (w_s3[off(3, c) + 3 * i + 2]),
                .sum (w_s4[off(4, c) + i]),
                .cout(w_s4[cin_idx(4, c + 1) + i])
            );
        end
        for (genvar j = 0; j < ha_cnt(4, c); j++) begin : g_ha
            half_adder u_ha (
                .a   (w_s3[off(3, c) + 3 * fa_cnt(4, c) + 2 * j]),
                .b   (w_s3[off(3, c) + 3 * fa_cnt(4, c) + 2 * j + 1]),
                .sum (w_s4[off(4, c) + fa_cnt(4, c) + j]),
                .cout(w_s4[cin_idx(4, c + 1) + fa_cnt(4, c) + j])
            );
        end
        for (genvar p = 0; p < pass_cnt(4, c); p++) begin : g_pass
            assign w_s4[off(4, c) + fa_cnt(4, c) + ha_cnt(4, c) + p] =
                   w_s3[off(3, c) + 3 * fa_cnt(4, c) + 2 * ha_cnt(4, c) + p];
        end
    end

    // Final ripple adder over the two remaining rows. Column 0 holds a single
    // bit, so the chain starts at column 1 with a half adder. Each column
    // keeps its own carry wire so the chain is not one self-feeding vector.
    assign w_prod[0] = w_s4[0];
    for (genvar c = 1; c < NCOLS; c++) begin : g_cpa
        logic w_co;
        if (c == 1) begin : g_ha
            half_adder u_ha (
                .a   (w_s4[off(4, c)]),
                .b   (w_s4[off(4, c) + 1]),
                .sum (w_prod[c]),
                .cout(w_co)
            );
        end else begin : g_fa
            full_adder u_fa (
                .a   (w_s4[off(4, c)]),
                .b   (w_s4[off(4, c) + 1]),
                .cin (g_cpa[c - 1].w_co),
                .sum (w_prod[c]),
                .cout(w_co)
            );
        end
    end
    assign w_prod[PROD_W-1] = g_cpa[NCOLS-1].w_co;

    // Output register: cleared synchronously, otherwise captures the product.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_op <= '0;
        else
            r_op <= w_prod;
    end

    assign op = r_op;

endmodule

// File: tb/tb_dadda_mul8.sv
// Bench for dadda_mul8: a one-cycle arithmetic reference model checked every
// cycle, plus literal expectations for reset, directed and corner products.
module tb_dadda_mul8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] op;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [15:0] m_exp;
    logic        m_valid = 1'b0;

    dadda_mul8 dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .b    (b),
        .op   (op)
    );

    always #5 clk = ~clk;

    // Reference model: what the output register must hold after each edge.
    always @(posedge clk) begin
        m_exp   <= rst_n ? ({8'h00, a} * {8'h00, b}) : 16'h0000;
        m_valid <= 1'b1;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            n_checks++;
            if (op !== m_exp) begin
                n_fail++;
                $display("FAIL model t=%0t: op=%h required=%h", $time, op, m_exp);
            end
        end
    end

    task automatic lit(input string name, input logic [15:0] req);
        n_checks++;
        if (op !== req) begin
            n_fail++;
            $display("FAIL %s: op=%h required=%h", name, op, req);
        end
    endtask

    // Apply operands at a falling edge and wait for the next falling edge,
    // by which time the rising edge in between has registered them.
    task automatic step(input logic [7:0] x, input logic [7:0] y, input logic r);
        a     = x;
        b     = y;
        rst_n = r;
        @(negedge clk);
    endtask

    logic [7:0]  da [10] = '{8'd43, 8'd43, 8'd43, 8'd47, 8'd11, 8'd235, 8'd0,   8'd1,   8'd128, 8'd255};
    logic [7:0]  db [10] = '{8'd9,  8'd73, 8'd11, 8'd9,  8'd41, 8'd9,   8'd255, 8'd200, 8'd128, 8'd1};
    logic [15:0] dq [10] = '{16'h0183, 16'h0C43, 16'h01D9, 16'h01A7, 16'h01C3,
                             16'h0843, 16'h0000, 16'h00C8, 16'h4000, 16'h00FF};

    initial begin
        a     = 8'hFF;
        b     = 8'hFF;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        lit("reset", 16'h0000);
        step(8'hFF, 8'hFF, 1'b1);
        lit("release", 16'hFE01);

        for (int k = 0; k < 10; k++) begin
            step(da[k], db[k], 1'b1);
            lit($sformatf("directed_%0d", k), dq[k]);
        end

        step(8'd43, 8'd9, 1'b1);
        lit("b2b_0", 16'h0183);
        step(8'd43, 8'd73, 1'b1);
        lit("b2b_1", 16'h0C43);
        step(8'd255, 8'd255, 1'b1);
        lit("b2b_2", 16'hFE01);

        step(8'd200, 8'd100, 1'b1);
        lit("stream_pre", 16'h4E20);
        step(8'd77, 8'd99, 1'b0);
        lit("stream_reset", 16'h0000);
        step(8'd3, 8'd5, 1'b1);
        lit("stream_resume", 16'h000F);

        for (int k = 0; k < 2000; k++)
            step(8'($urandom_range(255)), 8'($urandom_range(255)), ($urandom_range(31) != 0));

        for (int ia = 0; ia < 256; ia++)
            for (int ib = 0; ib < 256; ib++)
                step(8'(ia), 8'(ib), 1'b1);
        step(8'd0, 8'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
